// File: rtl/imem_port_arbiter_if.sv
// Bundle for imem_port_arbiter: fetch read port, loader write port and the
// instruction-memory side. slave = arbiter view, master = requesters + memory.
interface imem_port_arbiter_if;
    logic        f_req;
    logic [31:0] f_adr;
    logic        f_gnt;
    logic [31:0] f_rdata;
    logic        f_valid;
    logic        l_req;
    logic [31:0] l_adr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_done;
    logic        l_err;
    logic [31:0] mem_adr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [15:0] mem_wadr;
    logic [7:0]  mem_wbyte;
    logic        busy;

    modport slave (
        input  f_req, f_adr, l_req, l_adr, l_wdata, mem_rdata,
        output f_gnt, f_rdata, f_valid, l_gnt, l_done, l_err,
               mem_adr, mem_we, mem_wadr, mem_wbyte, busy
    );

    modport master (
        output f_req, f_adr, l_req, l_adr, l_wdata, mem_rdata,
        input  f_gnt, f_rdata, f_valid, l_gnt, l_done, l_err,
               mem_adr, mem_we, mem_wadr, mem_wbyte, busy
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Fetch/loader arbiter for a byte-write instruction memory; loader words go out as 4 byte writes.
// Optional post-write readback check enabled by `define IMEM_ARB_VERIFY_EN.
module imem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef struct packed {
        logic [15:0] adr;
        logic [31:0] data;
    } wr_req_t;

`ifdef IMEM_ARB_VERIFY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_VERIFY} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_WRITE} state_t;
`endif

    state_t      state, state_nxt;
    logic [1:0]  k, k_nxt;
    logic [3:0]  starve, starve_nxt;
    wr_req_t     wr_q;
    logic [31:0] f_rdata_q;
    logic        f_valid_q, l_done_q, done_set;
    logic        idle, l_win, f_win;
    logic        unused_adr_hi;

    assign unused_adr_hi = ^{bus.f_adr[31:16], bus.l_adr[31:16]};

    // Loader only preempts a pending fetch once fetch has used its starvation budget.
    assign idle  = (state == ST_IDLE);
    assign l_win = idle && bus.l_req && (!bus.f_req || starve == STARVE_LIM);
    assign f_win = idle && bus.f_req && !l_win;

    assign bus.f_gnt     = f_win;
    assign bus.l_gnt     = l_win;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.f_valid   = f_valid_q;
    assign bus.l_done    = l_done_q;
    assign bus.busy      = !idle;
    assign bus.mem_we    = (state == ST_WRITE);
    assign bus.mem_wadr  = wr_q.adr + {14'd0, k};
    assign bus.mem_wbyte = wr_q.data[{k, 3'b000} +: 8];

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        case (state)
            ST_IDLE: begin
                if (l_win) begin
                    state_nxt = ST_WRITE;
                    k_nxt     = 2'd0;
                end
            end
            ST_WRITE: begin
                k_nxt = k + 2'd1;
                if (k == 2'd3) begin
`ifdef IMEM_ARB_VERIFY_EN
                    state_nxt = ST_VERIFY;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef IMEM_ARB_VERIFY_EN
            ST_VERIFY: state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        starve_nxt = starve;
        if (l_win || !bus.l_req)
            starve_nxt = 4'd0;
        else if (f_win && starve != STARVE_LIM)
            starve_nxt = starve + 4'd1;
    end

`ifdef IMEM_ARB_VERIFY_EN
    logic l_err_q;

    assign done_set    = (state == ST_VERIFY);
    assign bus.l_err   = l_err_q;
    assign bus.mem_adr = (state == ST_VERIFY) ? {16'd0, wr_q.adr} : {16'd0, bus.f_adr[15:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            l_err_q <= 1'b0;
        else
            l_err_q <= (state == ST_VERIFY) && (bus.mem_rdata != wr_q.data);
    end
`else
    assign done_set    = (state == ST_WRITE) && (k == 2'd3);
    assign bus.l_err   = 1'b0;
    assign bus.mem_adr = {16'd0, bus.f_adr[15:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k         <= 2'd0;
            starve    <= 4'd0;
            wr_q      <= '0;
            f_rdata_q <= 32'd0;
            f_valid_q <= 1'b0;
            l_done_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            starve    <= starve_nxt;
            f_valid_q <= f_win;
            l_done_q  <= done_set;
            if (f_win)
                f_rdata_q <= bus.mem_rdata;
            if (l_win) begin
                wr_q.adr  <= bus.l_adr[15:0];
                wr_q.data <= bus.l_wdata;
            end
        end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: byte-array memory model plus a
// reference byte image updated from the write rules (A+k wrap, little-endian).
module tb_imem_port_arbiter;
    localparam int STARVE_MAX = 4;
`ifdef IMEM_ARB_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_adr = 16'd0;

    imem_port_arbiter_if bus ();

    imem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = {mem[bus.mem_adr[15:0] + 16'd3], mem[bus.mem_adr[15:0] + 16'd2],
                            mem[bus.mem_adr[15:0] + 16'd1], mem[bus.mem_adr[15:0]]};

    always @(posedge clk)
        if (bus.mem_we)
            mem[bus.mem_wadr] <= (corrupt_en && bus.mem_wadr == corrupt_adr) ? ~bus.mem_wbyte
                                                                              : bus.mem_wbyte;

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        return {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Back-to-back fetches, one per cycle; entered and left on a falling edge.
    task automatic fetch_stream(input logic [15:0] adr_q[$]);
        logic [31:0] exp_prev;
        exp_prev = 32'd0;
        for (int i = 0; i <= adr_q.size(); i++) begin
            if (i < adr_q.size()) begin
                bus.f_req = 1'b1;
                bus.f_adr = {16'($urandom), adr_q[i]};
            end else begin
                bus.f_req = 1'b0;
            end
            #1;
            if (i < adr_q.size()) begin
                chk("f_gnt", bus.f_gnt, 1'b1);
                chk("l_gnt_fetch", bus.l_gnt, 1'b0);
                chk("mem_adr", bus.mem_adr, {16'd0, adr_q[i]});
            end
            chk("f_valid", bus.f_valid, i > 0);
            if (i > 0) chk("f_rdata", bus.f_rdata, exp_prev);
            if (i < adr_q.size()) exp_prev = ref_word(adr_q[i]);
            @(negedge clk);
        end
    endtask

    // Full loader transaction; f_req/f_adr are whatever the caller left driven.
    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input bit corrupt,
                            output int fgrants);
        int          waited;
        logic [15:0] wa;
        logic [7:0]  b;
        waited      = 0;
        fgrants     = 0;
        corrupt_en  = corrupt;
        corrupt_adr = a + 16'd2;
        bus.l_req   = 1'b1;
        bus.l_adr   = {16'($urandom), a};
        bus.l_wdata = d;
        #1;
        while (!bus.l_gnt && waited < 32) begin
            chk("f_gnt_wait", bus.f_gnt, bus.f_req);
            if (bus.f_gnt) fgrants++;
            @(negedge clk);
            #1;
            waited++;
        end
        chk("l_gnt", bus.l_gnt, 1'b1);
        chk("gnt_excl", bus.f_gnt, 1'b0);
        if (!bus.l_gnt) begin
            bus.l_req = 1'b0;
            return;
        end
        @(negedge clk);
        bus.l_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            wa = a + 16'(k);
            b  = d[8*k +: 8];
            chk("mem_we", bus.mem_we, 1'b1);
            chk("mem_wadr", bus.mem_wadr, wa);
            chk("mem_wbyte", bus.mem_wbyte, b);
            chk("busy", bus.busy, 1'b1);
            chk("f_gnt_write", bus.f_gnt, 1'b0);
            chk("l_gnt_write", bus.l_gnt, 1'b0);
            chk("l_done_early", bus.l_done, 1'b0);
            ref_mem[wa] = (corrupt && k == 2) ? ~b : b;
            @(negedge clk);
        end
`ifdef IMEM_ARB_VERIFY_EN
        #1;
        chk("verify_we", bus.mem_we, 1'b0);
        chk("verify_busy", bus.busy, 1'b1);
        chk("verify_f_gnt", bus.f_gnt, 1'b0);
        chk("verify_adr", bus.mem_adr, {16'd0, a});
        chk("verify_done_early", bus.l_done, 1'b0);
        @(negedge clk);
`endif
        #1;
        chk("l_done", bus.l_done, 1'b1);
        chk("l_err", bus.l_err, VERIFY && corrupt);
        chk("busy_end", bus.busy, 1'b0);
        chk("mem_we_end", bus.mem_we, 1'b0);
        chk("f_gnt_resume", bus.f_gnt, bus.f_req);
        corrupt_en = 1'b0;
        bus.f_req  = 1'b0;
        @(negedge clk);
        #1;
        chk("l_done_pulse", bus.l_done, 1'b0);
        chk("l_err_pulse", bus.l_err, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q[$];
        int          fg;
        logic [15:0] a;
        logic [31:0] d;
        bit          fh;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[i]         = 8'(32'h8C011000 >> (8*i));
            mem[4 + i]     = 8'(32'h24020000 >> (8*i));
            ref_mem[i]     = mem[i];
            ref_mem[4 + i] = mem[4 + i];
        end

        bus.f_req = 1'b0; bus.f_adr = 32'd0;
        bus.l_req = 1'b0; bus.l_adr = 32'd0; bus.l_wdata = 32'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_f_valid", bus.f_valid, 1'b0);
        chk("rst_f_rdata", bus.f_rdata, 32'd0);
        chk("rst_l_done", bus.l_done, 1'b0);
        chk("rst_l_err", bus.l_err, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_l_gnt", bus.l_gnt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back fetch over the two preset words.
        q = '{16'h0000, 16'h0004, 16'h0000, 16'h0004, 16'h0004, 16'h0000};
        fetch_stream(q);

        // Idle write with no fetch contention, then read it back.
        do_write(16'h0100, 32'hDEADBEEF, 1'b0, fg);
        chk("idle_fgrants", 32'(fg), 32'd0);
        q = '{16'h0100, 16'h0101};
        fetch_stream(q);

        // Continuous fetch: loader gets in after exactly STARVE_MAX fetch grants.
        bus.f_req = 1'b1;
        bus.f_adr = 32'h0000_0004;
        do_write(16'h0300, 32'hCAFEF00D, 1'b0, fg);
        chk("starve_fgrants", 32'(fg), 32'(STARVE_MAX));
        q = '{16'h0300, 16'h0004};
        fetch_stream(q);

        // Address wrap at the top of memory.
        do_write(16'hFFFE, 32'h11223344, 1'b0, fg);
        q = '{16'hFFFE, 16'h0000, 16'hFFFC};
        fetch_stream(q);

        // Readback mismatch on byte 2 (l_err only with the verify build).
        do_write(16'h0400, 32'h55AA33CC, 1'b1, fg);
        q = '{16'h0400};
        fetch_stream(q);

        // Reset asserted after bytes 0 and 1 of a write to 0x0200.
        bus.l_req = 1'b1; bus.l_adr = 32'h0000_0200; bus.l_wdata = 32'hA1B2C3D4;
        #1;
        chk("abort_l_gnt", bus.l_gnt, 1'b1);
        @(negedge clk);
        bus.l_req = 1'b0;
        ref_mem[16'h0200] = 8'hD4;
        ref_mem[16'h0201] = 8'hC3;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", bus.mem_we, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_l_done", bus.l_done, 1'b0);
        chk("abort_f_valid", bus.f_valid, 1'b0);
        chk("abort_f_rdata", bus.f_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("abort_no_done", bus.l_done, 1'b0);
            chk("abort_idle", bus.busy, 1'b0);
            @(negedge clk);
        end
        q = '{16'h0200, 16'h01FE};
        fetch_stream(q);

        // Randomized writes with and without fetch contention, each read back.
        for (int it = 0; it < 14; it++) begin
            a  = 16'($urandom);
            d  = $urandom;
            fh = 1'($urandom_range(0, 1));
            bus.f_req = fh;
            bus.f_adr = {16'($urandom), 16'($urandom)};
            do_write(a, d, 1'($urandom_range(0, 1)), fg);
            chk("rand_fgrants", 32'(fg), fh ? 32'(STARVE_MAX) : 32'd0);
            q = '{a, a + 16'd2, 16'($urandom)};
            fetch_stream(q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
